// File: rtl/ro_pkg.sv
// Shared constants and width helpers for the multi-channel readout merger.
package ro_pkg;

  localparam int ARB_RR = 0;
  localparam int ARB_FP = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ch_id_w(input int n_ch);
    return (n_ch > 1) ? clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/ro_sync_fifo.sv
// Single-clock FIFO with extended pointers and registered full/empty flags.
module ro_sync_fifo
  import ro_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              wr_en, rd_en;

  assign wr_en = wr & ~full_q;
  assign rd_en = rd & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
    full_d   = (wr_ptr_d - rd_ptr_d) == (AW+1)'(DEPTH);
    empty_d  = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ro_multi_ch_merger.sv
// N-channel readout merger: per-channel FIFOs, RR/FP arbiter, one output register,
// sticky full flags and a saturating drop counter.
module ro_multi_ch_merger
  import ro_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ARB_MODE = 0
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset,
  input  logic [N_CH*DATA_W-1:0]            ch_writedata,
  input  logic [N_CH-1:0]                   ch_write,
  output logic [N_CH-1:0]                   ch_waitrequest,
  input  logic [N_CH-1:0]                   ch_enable,
  output logic [ch_id_w(N_CH)+DATA_W-1:0]   out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N_CH-1:0]                   status_full_export,
  input  logic                              status_clear,
  output logic [15:0]                       drop_count
);

  localparam int CH_W = ch_id_w(N_CH);
  localparam int AW   = clog2(DEPTH);

  logic [N_CH-1:0]   fifo_wr, fifo_rd, fifo_empty, fifo_full, full_set, drop_hit;
  logic [DATA_W-1:0] fifo_rdata [N_CH];
  logic [AW:0]       fifo_count [N_CH];

  logic [CH_W-1:0]        grant, rr_ptr_q, rr_ptr_d;
  logic                   grant_valid, load;
  logic [CH_W+DATA_W-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [N_CH-1:0]        sticky_q, sticky_d;
  logic [15:0]            drop_q, drop_d;
  logic [4:0]             drop_inc;
  logic [16:0]            drop_sum;

  // A disabled channel never stalls its master; its words go to the drop counter.
  assign ch_waitrequest = fifo_full & ch_enable;
  assign fifo_wr        = ch_write & ch_enable & ~fifo_full;
  assign drop_hit       = ch_write & ~ch_enable;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ro_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk_clk),
      .rst     (reset_reset),
      .wr      (fifo_wr[c]),
      .wr_data (ch_writedata[c*DATA_W +: DATA_W]),
      .rd      (fifo_rd[c]),
      .rd_data (fifo_rdata[c]),
      .empty   (fifo_empty[c]),
      .full    (fifo_full[c]),
      .count   (fifo_count[c])
    );
    assign full_set[c] = fifo_wr[c] & ~fifo_rd[c] &
                         (fifo_count[c] == (AW+1)'(DEPTH-1));
  end

  // Scan from the highest offset down so the lowest offset from the base wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      idx = (ARB_MODE == ARB_FP) ? i : int'(rr_ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant       = CH_W'(idx);
      end
    end
  end

  assign load = (~out_valid_q | out_ready) & grant_valid;

  always_comb begin
    fifo_rd     = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      fifo_rd[grant] = 1'b1;
      out_data_d     = {grant, fifo_rdata[grant]};
      out_valid_d    = 1'b1;
      if (ARB_MODE == ARB_RR)
        rr_ptr_d = (int'(grant) == N_CH-1) ? '0 : grant + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    drop_inc = '0;
    for (int c = 0; c < N_CH; c++) drop_inc = drop_inc + 5'(drop_hit[c]);
    drop_sum = {1'b0, drop_q} + 17'(drop_inc);
    if (status_clear)     drop_d = '0;
    else if (drop_sum[16]) drop_d = 16'hFFFF;
    else                  drop_d = drop_sum[15:0];
    sticky_d = status_clear ? '0 : (sticky_q | full_set);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      sticky_q    <= '0;
      drop_q      <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      sticky_q    <= sticky_d;
      drop_q      <= drop_d;
    end
  end

  assign out_data           = out_data_q;
  assign out_valid          = out_valid_q;
  assign status_full_export = sticky_q;
  assign drop_count         = drop_q;

endmodule

// File: tb/tb_ro_multi_ch_merger.sv
// Directed bench: a round-robin and a fixed-priority instance share all stimulus.
module tb_ro_multi_ch_merger;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] wdata;
  logic [1:0]  wr, en;
  logic        ready, clr;

  logic [1:0]  wreq_rr, sf_rr, wreq_fp, sf_fp;
  logic [32:0] od_rr, od_fp;
  logic        ov_rr, ov_fp;
  logic [15:0] dc_rr, dc_fp;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ro_multi_ch_merger #(.N_CH(2), .DATA_W(32), .DEPTH(16), .ARB_MODE(0)) u_rr (
    .clk_clk(clk), .reset_reset(rst), .ch_writedata(wdata), .ch_write(wr),
    .ch_waitrequest(wreq_rr), .ch_enable(en), .out_data(od_rr), .out_valid(ov_rr),
    .out_ready(ready), .status_full_export(sf_rr), .status_clear(clr), .drop_count(dc_rr)
  );

  ro_multi_ch_merger #(.N_CH(2), .DATA_W(32), .DEPTH(16), .ARB_MODE(1)) u_fp (
    .clk_clk(clk), .reset_reset(rst), .ch_writedata(wdata), .ch_write(wr),
    .ch_waitrequest(wreq_fp), .ch_enable(en), .out_data(od_fp), .out_valid(ov_fp),
    .out_ready(ready), .status_full_export(sf_fp), .status_clear(clr), .drop_count(dc_fp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = '0; en = 2'b11; ready = 1'b0; clr = 1'b0; wdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = '0; en = 2'b11; ready = 1'b0; clr = 1'b0; wdata = '0;
    step();
    step();
    n_total++; if (ov_rr !== 1'b0) $display("FAIL reset_valid: got %b exp 0", ov_rr); else n_pass++;
    n_total++; if (od_rr !== 33'h0) $display("FAIL reset_data: got %h exp 0", od_rr); else n_pass++;
    n_total++; if (wreq_rr !== 2'b00) $display("FAIL reset_waitreq: got %b exp 00", wreq_rr); else n_pass++;
    n_total++; if (sf_rr !== 2'b00) $display("FAIL reset_sticky: got %b exp 00", sf_rr); else n_pass++;
    n_total++; if (dc_rr !== 16'h0) $display("FAIL reset_drop: got %h exp 0", dc_rr); else n_pass++;
    rst = 1'b0;
  endtask

  // Word accepted at edge E1 shows at the output after E2; stream then runs 1/cycle.
  task automatic test_single_stream();
    logic [32:0] exp;
    do_reset();
    ready = 1'b1;
    wr = 2'b01; wdata = {32'h0, 32'hA0};
    step();
    n_total++; if (ov_rr !== 1'b0) $display("FAIL stream_latency: valid=%b one edge after first write, exp 0", ov_rr); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) wdata = {32'h0, 32'(32'hA1 + k)};
      else wr = 2'b00;
      step();
      exp = {1'b0, 32'(32'hA0 + k)};
      n_total++;
      if (ov_rr !== 1'b1 || od_rr !== exp)
        $display("FAIL stream_word%0d: got v=%b d=%h exp v=1 d=%h", k, ov_rr, od_rr, exp);
      else n_pass++;
    end
    step();
    n_total++; if (ov_rr !== 1'b0) $display("FAIL stream_end: valid=%b exp 0", ov_rr); else n_pass++;
  endtask

  task automatic test_arbitration();
    logic [32:0] exp_rr, exp_fp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr = 2'b11; wdata = {32'(32'hC0 + i), 32'(32'hB0 + i)};
      step();
    end
    wr = 2'b00;
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_rr = (k % 2 == 0) ? {1'b0, 32'(32'hB0 + k/2)} : {1'b1, 32'(32'hC0 + k/2)};
      exp_fp = (k < 4) ? {1'b0, 32'(32'hB0 + k)} : {1'b1, 32'(32'hC0 + k - 4)};
      n_total++;
      if (ov_rr !== 1'b1 || od_rr !== exp_rr)
        $display("FAIL arb_rr%0d: got v=%b d=%h exp v=1 d=%h", k, ov_rr, od_rr, exp_rr);
      else n_pass++;
      n_total++;
      if (ov_fp !== 1'b1 || od_fp !== exp_fp)
        $display("FAIL arb_fp%0d: got v=%b d=%h exp v=1 d=%h", k, ov_fp, od_fp, exp_fp);
      else n_pass++;
      step();
    end
    n_total++;
    if (ov_rr !== 1'b0 || ov_fp !== 1'b0)
      $display("FAIL arb_drain: got rr=%b fp=%b exp 0 0", ov_rr, ov_fp);
    else n_pass++;
  endtask

  // With ready low the output register absorbs D0, so the FIFO fills on word index 16.
  task automatic test_full_backpressure();
    int   idx, k, cyc;
    logic acc, sf_before, hold_ok;
    do_reset();
    idx = 0; sf_before = 1'b1;
    wr = 2'b01; wdata = {32'h0, 32'hD000_0000};
    for (cyc = 0; cyc < 40 && idx < 17; cyc++) begin
      acc = ~wreq_rr[0];
      if (idx == 16) sf_before = sf_rr[0];
      step();
      if (acc) idx++;
      wdata = {32'h0, 32'(32'hD000_0000 + idx)};
    end
    n_total++; if (idx != 17) $display("FAIL full_fill: accepted %0d exp 17", idx); else n_pass++;
    n_total++; if (sf_before !== 1'b0) $display("FAIL full_sticky_early: got %b exp 0", sf_before); else n_pass++;
    n_total++; if (wreq_rr[0] !== 1'b1) $display("FAIL full_waitreq: got %b exp 1", wreq_rr[0]); else n_pass++;
    n_total++; if (sf_rr[0] !== 1'b1) $display("FAIL full_sticky: got %b exp 1", sf_rr[0]); else n_pass++;
    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wreq_rr[0] !== 1'b1 || od_rr !== {1'b0, 32'hD000_0000}) hold_ok = 1'b0;
    end
    n_total++; if (hold_ok !== 1'b1) $display("FAIL full_hold: got wreq=%b d=%h exp 1 and D0", wreq_rr[0], od_rr); else n_pass++;
    ready = 1'b1;
    k = 0;
    for (cyc = 0; cyc < 40 && k < 18; cyc++) begin
      if (ov_rr) begin
        n_total++;
        if (od_rr !== {1'b0, 32'(32'hD000_0000 + k)})
          $display("FAIL full_drain%0d: got %h exp %h", k, od_rr, {1'b0, 32'(32'hD000_0000 + k)});
        else n_pass++;
        k++;
      end
      acc = wr[0] & ~wreq_rr[0];
      step();
      if (acc) wr = 2'b00;
    end
    n_total++; if (k != 18) $display("FAIL full_drain_count: got %0d exp 18", k); else n_pass++;
    n_total++; if (sf_rr[0] !== 1'b1) $display("FAIL full_sticky_hold: got %b exp 1", sf_rr[0]); else n_pass++;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_total++; if (sf_rr[0] !== 1'b0) $display("FAIL full_sticky_clear: got %b exp 0", sf_rr[0]); else n_pass++;
  endtask

  task automatic test_disabled_drop();
    logic any_valid, any_wreq;
    do_reset();
    ready = 1'b1; en = 2'b01;
    any_valid = 1'b0; any_wreq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr = 2'b10; wdata = {32'(32'hE0 + i), 32'h0};
      if (wreq_rr[1]) any_wreq = 1'b1;
      step();
      if (ov_rr) any_valid = 1'b1;
    end
    wr = 2'b00;
    step();
    if (ov_rr) any_valid = 1'b1;
    step();
    if (ov_rr) any_valid = 1'b1;
    n_total++; if (any_valid !== 1'b0) $display("FAIL drop_no_output: valid seen=%b exp 0", any_valid); else n_pass++;
    n_total++; if (any_wreq !== 1'b0) $display("FAIL drop_waitreq: seen=%b exp 0", any_wreq); else n_pass++;
    n_total++; if (dc_rr !== 16'd5) $display("FAIL drop_count: got %0d exp 5", dc_rr); else n_pass++;
    wr = 2'b10; clr = 1'b1;
    step();
    wr = 2'b00; clr = 1'b0;
    n_total++; if (dc_rr !== 16'd0) $display("FAIL drop_clear_wins: got %0d exp 0", dc_rr); else n_pass++;
    wr = 2'b10;
    step();
    wr = 2'b00;
    n_total++; if (dc_rr !== 16'd1) $display("FAIL drop_after_clear: got %0d exp 1", dc_rr); else n_pass++;
    en = 2'b11;
  endtask

  task automatic test_hold_stable();
    logic hold_ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr = 2'b01; wdata = {32'h0, 32'(32'hF0 + i)};
      step();
    end
    wr = 2'b00;
    n_total++; if (ov_rr !== 1'b1 || od_rr !== {1'b0, 32'hF0}) $display("FAIL hold_first: got v=%b d=%h exp 1 F0", ov_rr, od_rr); else n_pass++;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ov_rr !== 1'b1 || od_rr !== {1'b0, 32'hF0}) hold_ok = 1'b0;
    end
    n_total++; if (hold_ok !== 1'b1) $display("FAIL hold_stable: got v=%b d=%h exp 1 F0", ov_rr, od_rr); else n_pass++;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (ov_rr !== 1'b1 || od_rr !== {1'b0, 32'(32'hF0 + k)})
        $display("FAIL hold_release%0d: got v=%b d=%h exp 1 %h", k, ov_rr, od_rr, 32'(32'hF0 + k));
      else n_pass++;
      step();
    end
    n_total++; if (ov_rr !== 1'b0) $display("FAIL hold_no_dup: valid=%b exp 0", ov_rr); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic any_valid;
    do_reset();
    en = 2'b01;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) en = 2'b11;
      wr = 2'b11; wdata = {32'(32'h5100 + i), 32'(32'h5000 + i)};
      step();
    end
    wr = 2'b00;
    n_total++;
    if (ov_rr !== 1'b1 || dc_rr !== 16'd2)
      $display("FAIL mid_pre: got v=%b drop=%0d exp 1 2", ov_rr, dc_rr);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (ov_rr !== 1'b0 || od_rr !== 33'h0 || wreq_rr !== 2'b00 || sf_rr !== 2'b00 || dc_rr !== 16'h0)
      $display("FAIL mid_reset: got v=%b d=%h wr=%b sf=%b dc=%h exp all 0", ov_rr, od_rr, wreq_rr, sf_rr, dc_rr);
    else n_pass++;
    step();
    rst = 1'b0;
    ready = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ov_rr) any_valid = 1'b1;
    end
    n_total++; if (any_valid !== 1'b0) $display("FAIL mid_empty: valid seen=%b exp 0", any_valid); else n_pass++;
    wr = 2'b10; wdata = {32'h7777_0001, 32'h0};
    step();
    wr = 2'b00;
    step();
    n_total++;
    if (ov_rr !== 1'b1 || od_rr !== {1'b1, 32'h7777_0001})
      $display("FAIL mid_recover: got v=%b d=%h exp 1 %h", ov_rr, od_rr, {1'b1, 32'h7777_0001});
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_stream();
    test_arbitration();
    test_full_backpressure();
    test_disabled_drop();
    test_hold_stable();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
